// File: rtl/gpr_pkg.sv
// Shared definitions for the multi-port GPR: FSM encoding, default sizes and a bus field helper.
package gpr_pkg;

  localparam int unsigned DefDw    = 32;
  localparam int unsigned DefAw    = 5;
  localparam int unsigned DefNr    = 2;
  localparam int unsigned MaxBus   = 256;
  localparam int unsigned FieldMax = 32;

  typedef enum logic [0:0] {
    StIdle  = 1'b0,
    StSweep = 1'b1
  } gpr_state_e;

  // Returns field i (w bits wide) of a flat bus, zero-extended to FieldMax bits.
  function automatic logic [FieldMax-1:0] get_field(input logic [MaxBus-1:0] bus,
                                                    input int unsigned i,
                                                    input int unsigned w);
    logic [MaxBus-1:0] shifted;
    logic [MaxBus-1:0] mask;
    shifted = bus >> (i * w);
    mask    = (MaxBus'(1) << w) - MaxBus'(1);
    return FieldMax'(shifted & mask);
  endfunction

endpackage

// File: rtl/gpr_read_port.sv
// One combinational read port: zero-register handling, write-through bypass and pend masking.
module gpr_read_port
  import gpr_pkg::*;
#(
  parameter int unsigned DW       = DefDw,
  parameter int unsigned AW       = DefAw,
  parameter bit          ZERO_REG = 1'b1,
  parameter bit          BYPASS   = 1'b1
) (
  input  logic [AW-1:0] ra,
  input  logic [DW-1:0] stored,
  input  logic          stored_pend,
  input  logic          we0,
  input  logic [AW-1:0] wa0,
  input  logic [DW-1:0] wd0,
  input  logic          we1,
  input  logic [AW-1:0] wa1,
  input  logic [DW-1:0] wd1,
  input  logic          iss_v,
  input  logic [AW-1:0] iss_a,
  output logic [DW-1:0] rd,
  output logic          pend
);

  logic hit0, hit1;

  // Enables arrive already gated by reset and sweep, so no bypass happens then.
  assign hit0 = BYPASS && we0 && (wa0 == ra);
  assign hit1 = BYPASS && we1 && (wa1 == ra);

  always_comb begin
    rd   = stored;
    pend = stored_pend;
    if (ZERO_REG && (ra == '0)) begin
      rd   = '0;
      pend = 1'b0;
    end else begin
      if (hit1) begin
        rd = wd1;
      end else if (hit0) begin
        rd = wd0;
      end
      if ((hit0 || hit1) && !(iss_v && (iss_a == ra))) begin
        pend = 1'b0;
      end
    end
  end

endmodule

// File: rtl/gpr_mp.sv
// Multi-port GPR: two prioritised write lanes, NR read ports, pending-write scoreboard
// and a one-register-per-cycle clear sweep.
module gpr_mp
  import gpr_pkg::*;
#(
  parameter int unsigned DW       = DefDw,
  parameter int unsigned AW       = DefAw,
  parameter int unsigned NR       = DefNr,
  parameter bit          ZERO_REG = 1'b1,
  parameter bit          BYPASS   = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            we0,
  input  logic [AW-1:0]   wa0,
  input  logic [DW-1:0]   wd0,
  input  logic            we1,
  input  logic [AW-1:0]   wa1,
  input  logic [DW-1:0]   wd1,
  input  logic [NR*AW-1:0] ra,
  output logic [NR*DW-1:0] rd,
  output logic [NR-1:0]   pend,
  input  logic            iss_v,
  input  logic [AW-1:0]   iss_a,
  input  logic            clr_req,
  output logic            clr_busy
);

  localparam int unsigned Depth = 2 ** AW;

  logic [DW-1:0]    mem_q [Depth];
  logic [Depth-1:0] pend_q, pend_d;
  gpr_state_e       state_q, state_d;
  logic [AW-1:0]    cnt_q, cnt_d;
  logic             sweep;
  logic             we0_e, we1_e, iss_e;

  assign sweep = (state_q == StSweep);
  assign we0_e = we0 && !sweep && !rst && !(ZERO_REG && (wa0 == '0));
  assign we1_e = we1 && !sweep && !rst && !(ZERO_REG && (wa1 == '0));
  assign iss_e = iss_v && !sweep && !rst && !(ZERO_REG && (iss_a == '0));

  // Clear FSM: state register, next-state logic, outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (clr_req) begin
          state_d = StSweep;
          cnt_d   = '0;
        end
      end
      StSweep: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == '1) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    clr_busy = (state_q == StSweep);
  end

  // Lane 1 is assigned last so it wins an address conflict.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q <= '{default: '0};
    end else if (sweep) begin
      mem_q[cnt_q] <= '0;
    end else begin
      if (we0_e) mem_q[wa0] <= wd0;
      if (we1_e) mem_q[wa1] <= wd1;
    end
  end

  // Issue is applied last: a new producer outranks a retiring write to the same register.
  always_comb begin
    pend_d = pend_q;
    if (sweep) pend_d[cnt_q] = 1'b0;
    if (we0_e) pend_d[wa0] = 1'b0;
    if (we1_e) pend_d[wa1] = 1'b0;
    if (iss_e) pend_d[iss_a] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) pend_q <= '0;
    else     pend_q <= pend_d;
  end

  for (genvar i = 0; i < NR; i++) begin : g_rd
    logic [AW-1:0] ra_i;
    assign ra_i = AW'(get_field(MaxBus'(ra), i, AW));

    gpr_read_port #(
      .DW      (DW),
      .AW      (AW),
      .ZERO_REG(ZERO_REG),
      .BYPASS  (BYPASS)
    ) u_port (
      .ra         (ra_i),
      .stored     (mem_q[ra_i]),
      .stored_pend(pend_q[ra_i]),
      .we0        (we0_e),
      .wa0        (wa0),
      .wd0        (wd0),
      .we1        (we1_e),
      .wa1        (wa1),
      .wd1        (wd1),
      .iss_v      (iss_e),
      .iss_a      (iss_a),
      .rd         (rd[i*DW +: DW]),
      .pend       (pend[i])
    );
  end

endmodule

// File: tb/tb_gpr_mp.sv
// Scoreboard bench for gpr_mp: stimulus queues expectations, a negedge monitor checks them.
module tb_gpr_mp;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        we0 = 1'b0, we1 = 1'b0, iss_v = 1'b0, clr_req = 1'b0;
  logic [4:0]  wa0 = '0, wa1 = '0, iss_a = '0;
  logic [31:0] wd0 = '0, wd1 = '0;
  logic [9:0]  ra = '0;
  logic [63:0] rd, rd_nb;
  logic [1:0]  pend, pend_nb;
  logic        clr_busy, clr_busy_nb;

  always #5 clk = ~clk;

  gpr_mp #(.BYPASS(1'b1)) u_dut (
    .clk(clk), .rst(rst), .we0(we0), .wa0(wa0), .wd0(wd0), .we1(we1), .wa1(wa1), .wd1(wd1),
    .ra(ra), .rd(rd), .pend(pend), .iss_v(iss_v), .iss_a(iss_a), .clr_req(clr_req),
    .clr_busy(clr_busy)
  );

  gpr_mp #(.BYPASS(1'b0)) u_dut_nb (
    .clk(clk), .rst(rst), .we0(we0), .wa0(wa0), .wd0(wd0), .we1(we1), .wa1(wa1), .wd1(wd1),
    .ra(ra), .rd(rd_nb), .pend(pend_nb), .iss_v(iss_v), .iss_a(iss_a), .clr_req(clr_req),
    .clr_busy(clr_busy_nb)
  );

  // what: 0 rd port0, 1 rd port1, 2 pend bits, 3 clr_busy, 4 no-bypass rd port0
  typedef struct packed {
    logic [2:0]  what;
    logic [31:0] val;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  int    n_cmp = 0;
  int    n_bad = 0;

  task automatic chk(input string n, input logic [2:0] what, input logic [31:0] val);
    exp_t e;
    e.what = what;
    e.val  = val;
    exp_q.push_back(e);
    name_q.push_back(n);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    we0 = 1'b0; we1 = 1'b0; iss_v = 1'b0; clr_req = 1'b0;
  endtask

  always @(negedge clk) begin
    exp_t        e;
    string       n;
    logic [31:0] act;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n = name_q.pop_front();
      case (e.what)
        3'd0:    act = rd[31:0];
        3'd1:    act = rd[63:32];
        3'd2:    act = {30'd0, pend};
        3'd3:    act = {31'd0, clr_busy};
        default: act = rd_nb[31:0];
      endcase
      n_cmp++;
      if (act !== e.val) begin
        n_bad++;
        $display("FAIL %s: got %h expected %h at %0t", n, act, e.val, $time);
      end
    end
  end

  always @(posedge clk) begin
    if (!rst && !clr_busy) begin
      if (we0 && wa0 != 5'd0) $display("write lane 0 addr %0d data %h", wa0, wd0);
      if (we1 && wa1 != 5'd0) $display("write lane 1 addr %0d data %h", wa1, wd1);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset: outputs zero even with a write presented.
    step();
    ra = {5'd4, 5'd3};
    we0 = 1'b1; wa0 = 5'd3; wd0 = 32'h55;
    chk("rst_busy", 3'd3, 32'd0);
    chk("rst_pend", 3'd2, 32'd0);
    chk("rst_rd0", 3'd0, 32'd0);
    chk("rst_rd1", 3'd1, 32'd0);
    step();
    rst = 1'b0;
    idle_in();

    for (int a = 0; a < 32; a++) begin
      ra = {5'(31 - a), 5'(a)};
      chk("init_rd0", 3'd0, 32'd0);
      chk("init_rd1", 3'd1, 32'd0);
      chk("init_pend", 3'd2, 32'd0);
      chk("init_busy", 3'd3, 32'd0);
      step();
    end

    // Bypass vs no-bypass on a single write.
    we0 = 1'b1; wa0 = 5'd5; wd0 = 32'hDEADBEEF; ra = {5'd5, 5'd5};
    chk("byp_same", 3'd0, 32'hDEADBEEF);
    chk("nobyp_same", 3'd4, 32'd0);
    #1;
    n_cmp++;
    if (rd[31:0] !== 32'hDEADBEEF) begin
      n_bad++;
      $display("FAIL byp_direct: got %h at %0t", rd[31:0], $time);
    end
    step();
    idle_in();
    chk("byp_next", 3'd0, 32'hDEADBEEF);
    chk("nobyp_next", 3'd4, 32'hDEADBEEF);
    step();

    // Dual-write conflict: lane 1 wins.
    we0 = 1'b1; wa0 = 5'd7; wd0 = 32'd1;
    we1 = 1'b1; wa1 = 5'd7; wd1 = 32'd2;
    ra = {5'd7, 5'd7};
    chk("dual_byp", 3'd0, 32'd2);
    chk("dual_nobyp", 3'd4, 32'd0);
    step();
    idle_in();
    chk("dual_rd0", 3'd0, 32'd2);
    chk("dual_nb", 3'd4, 32'd2);
    #1;
    n_cmp++;
    if (rd_nb[31:0] !== 32'd2) begin
      n_bad++;
      $display("FAIL dual_direct: got %h at %0t", rd_nb[31:0], $time);
    end
    step();

    // Register 0 is hardwired.
    we0 = 1'b1; wa0 = 5'd0; wd0 = 32'd123; ra = {5'd0, 5'd0};
    chk("zero_same", 3'd0, 32'd0);
    step();
    idle_in();
    chk("zero_next", 3'd0, 32'd0);
    chk("zero_nb", 3'd4, 32'd0);
    step();

    // Scoreboard.
    iss_v = 1'b1; iss_a = 5'd9; ra = {5'd9, 5'd9};
    chk("iss_same", 3'd2, 32'd0);
    step();
    idle_in();
    chk("iss_next", 3'd2, 32'd3);
    step();
    we1 = 1'b1; wa1 = 5'd9; wd1 = 32'd77;
    chk("wr_clr_pend", 3'd2, 32'd0);
    chk("wr_clr_rd", 3'd0, 32'd77);
    #1;
    n_cmp++;
    if (pend !== 2'b00) begin
      n_bad++;
      $display("FAIL wr_clr_direct: got %b at %0t", pend, $time);
    end
    step();
    idle_in();
    chk("wr_clr_stay", 3'd2, 32'd0);
    chk("wr_clr_rd2", 3'd0, 32'd77);
    step();
    iss_v = 1'b1; iss_a = 5'd9; we0 = 1'b1; wa0 = 5'd9; wd0 = 32'd88;
    chk("isswr_pend", 3'd2, 32'd0);
    chk("isswr_rd", 3'd0, 32'd88);
    step();
    idle_in();
    chk("isswr_after", 3'd2, 32'd3);
    iss_v = 1'b1; iss_a = 5'd0;
    step();
    idle_in();
    ra = {5'd0, 5'd0};
    chk("iss_zero", 3'd2, 32'd0);
    step();

    // Fill registers, then issue on 12.
    for (int a = 1; a < 32; a++) begin
      we0 = 1'b1; wa0 = 5'(a); wd0 = 32'(a * 3 + 100);
      step();
    end
    idle_in();
    iss_v = 1'b1; iss_a = 5'd12;
    step();
    idle_in();
    ra = {5'd12, 5'd20};
    chk("fill_rd20", 3'd0, 32'd160);
    chk("fill_pend12", 3'd2, 32'd2);
    clr_req = 1'b1;
    chk("req_busy", 3'd3, 32'd0);
    step();
    clr_req = 1'b0;

    // Sweep: inputs hammered but ignored; reg 3 clears when the counter passes it.
    for (int c = 0; c < 32; c++) begin
      we0 = 1'b1; wa0 = 5'd3; wd0 = 32'hFFFF;
      iss_v = 1'b1; iss_a = 5'd4;
      clr_req = (c == 5);
      ra = {5'd4, 5'd3};
      chk("sweep_busy", 3'd3, 32'd1);
      chk("sweep_rd3", 3'd0, (c <= 3) ? 32'd109 : 32'd0);
      step();
    end
    idle_in();
    chk("sweep_done", 3'd3, 32'd0);
    for (int a = 0; a < 32; a++) begin
      ra = {5'(a), 5'(a)};
      chk("post_rd", 3'd0, 32'd0);
      chk("post_pend", 3'd2, 32'd0);
      step();
    end

    // Reset during sweep cycle 10.
    we0 = 1'b1; wa0 = 5'd20; wd0 = 32'h2020;
    step();
    idle_in();
    clr_req = 1'b1;
    step();
    clr_req = 1'b0;
    for (int c = 0; c < 10; c++) begin
      chk("rsw_busy", 3'd3, 32'd1);
      step();
    end
    rst = 1'b1; ra = {5'd20, 5'd20};
    chk("rsw_drop", 3'd3, 32'd0);
    chk("rsw_rd", 3'd0, 32'd0);
    step();
    rst = 1'b0;
    chk("rsw_after", 3'd0, 32'd0);
    chk("rsw_after_busy", 3'd3, 32'd0);
    we0 = 1'b1; wa0 = 5'd21; wd0 = 32'h21;
    step();
    idle_in();
    ra = {5'd21, 5'd21};
    chk("pre2_rd21", 3'd0, 32'h21);
    clr_req = 1'b1;
    step();
    clr_req = 1'b0;
    for (int c = 0; c < 32; c++) begin
      chk("sweep2_busy", 3'd3, 32'd1);
      step();
    end
    chk("sweep2_done", 3'd3, 32'd0);
    chk("sweep2_rd21", 3'd0, 32'd0);
    #1;
    n_cmp++;
    if (clr_busy !== 1'b0) begin
      n_bad++;
      $display("FAIL sweep2_direct: clr_busy %b at %0t", clr_busy, $time);
    end
    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/gpr_mp.md
Name: gpr_mp

Overview:
Parametrised general-purpose register file for the pipelined core. It generalises the single-write GPR to the following:
- NR combinational read ports and two prioritised write ports.
- Optional write-through bypass.
- A per-register pending-write scoreboard for hazard detection.
- A multi-cycle synchronous clear sweep.

It sits between decode (read and issue) and writeback (two retire lanes).

Parameters:
DW, 32, data width in bits
AW, 5, address width; depth = 2**AW registers
NR, 2, number of read ports
ZERO_REG, 1, 1 = register 0 reads as zero and ignores writes and issues
BYPASS, 1, 1 = same-cycle write data is forwarded to read ports and pend outputs

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  asynchronous, active-high reset
we0  in  1  write enable, lane 0
wa0  in  AW  write address, lane 0
wd0  in  DW  write data, lane 0
we1  in  1  write enable, lane 1 (higher priority)
wa1  in  AW  write address, lane 1
wd1  in  DW  write data, lane 1
ra  in  NR*AW  read addresses; port i at bits [i*AW +: AW]
rd  out  NR*DW  read data; port i at bits [i*DW +: DW]
pend  out  NR  pending flag of the register addressed by port i
iss_v  in  1  issue: mark register iss_a as awaiting a write
iss_a  in  AW  issue address
clr_req  in  1  start a synchronous clear sweep (one-cycle pulse)
clr_busy  out  1  sweep in progress

Behaviour:
- Reset (asynchronous, rst=1): all registers = 0, all pending bits = 0, FSM = IDLE, sweep counter = 0. While in reset: clr_busy=0, pend=0, rd=0.
- Write:
  - Edge-triggered.
  - Both lanes may write in the same cycle.
  - If wa0==wa1 with both enabled, lane 1 data is stored.
  - ZERO_REG=1: writes to address 0 are discarded.
- Read: combinational, zero latency. Per port, priority order:
  - ZERO_REG and ra_i==0 -> 0.
  - Else BYPASS and we1 and wa1==ra_i -> wd1.
  - Else BYPASS and we0 and wa0==ra_i -> wd0.
  - Else stored value.
- Scoreboard (one bit per register):
  - iss_v sets bit[iss_a]; ignored for address 0 when ZERO_REG=1.
  - A write on either lane clears bit[wa].
  - Same-cycle issue and write to the same address: set wins, since the new producer is outstanding.
  - pend_i = bit[ra_i]. If BYPASS=1, pend_i is forced to 0 when an enabled lane writes ra_i this cycle and iss_v does not target ra_i.
  - Address 0 with ZERO_REG=1: pend=0.
- Clear FSM, states IDLE and SWEEP:
  - IDLE: clr_req=1 -> SWEEP with counter=0.
  - SWEEP: clr_busy=1. Each cycle, reg[counter]=0 and bit[counter]=0, then counter+1.
  - When counter==2**AW-1: zero the final entry, return to IDLE, clr_busy=0 from the next cycle. The sweep takes exactly 2**AW cycles.
  - During SWEEP: we0, we1, iss_v and clr_req are ignored. Reads return current array contents; the bypass is inactive because writes are dropped.
  - Counter wraps to 0 on exit.
  - rst asserted mid-sweep: immediate IDLE, everything cleared.
- Width rules: addresses are unsigned; no truncation. The counter is AW bits wide.
- Simulation: each accepted write prints a display line giving lane, address and data.

Decomposition:
- Shared package gpr_pkg holds:
  - FSM state encoding (IDLE=0, SWEEP=1).
  - Default DW/AW/NR constants.
  - A function extracting field i from a flat bus.
- One natural sub-module: gpr_read_port, one combinational read mux plus bypass and pend logic, instantiated NR times with a generate loop.
- Storage, scoreboard and FSM live in the top level.

Test Plan:
- Reset then read all 32 addresses on both ports -> rd=0, pend=0, clr_busy=0.
- Write wd0=32'hDEADBEEF at wa0=5 while reading ra0=5 the same cycle:
  - With BYPASS=1 -> rd0=DEADBEEF that cycle and the next.
  - With BYPASS=0 -> rd0=0 that cycle, DEADBEEF the next.
- Dual-write conflict: we0,we1 both to addr 7, wd0=1, wd1=2 -> reg7=2. Write to addr 0 with ZERO_REG=1 -> reads 0.
- Scoreboard:
  - iss_v at addr 9 -> pend=1 from the next cycle.
  - Write to 9 -> pend=0 combinationally that cycle (BYPASS=1) and stays 0.
  - Issue and write addr 9 in the same cycle -> pend=1 afterwards.
- Sweep:
  - Fill regs with nonzero values, pulse clr_req -> clr_busy=1 for exactly 32 cycles.
  - Writes/issues during the sweep are dropped; all regs and pending bits are 0 after.
- Assert rst at sweep cycle 10 -> clr_busy drops immediately and all regs read 0. A new clr_req after reset runs a full 32-cycle sweep.
